cpu_run_ctrl: RTL and testbench

Parametrised run controller for the simplified MIPS CPU: it sequences the CPU reset, gates the CPU clock enable, counts executed cycles, and ends a run on a detected halt or a cycle-budget timeout. It sits between the top-level clock/reset and the `cpu` core. It replaces fixed, hand-written reset-and-run sequencing with a synthesizable block usable on the FPGA and in simulation. It adds pause, halt detection, restart and status reporting.

---
 rtl/cpu_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the simplified MIPS CPU: sequences CPU reset, gates the CPU
// clock enable, counts enabled cycles and ends a run on halt or cycle budget.
module cpu_run_ctrl #(
   parameter int unsigned RST_CYCLES = 5,
   parameter int unsigned MAX_CYCLES = 10000,
   parameter int unsigned HALT_HOLD  = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             halt_in,
   input  logic             pause,
   input  logic             restart,
   output logic             cpu_rst,
   output logic             cpu_en,
   output logic             running,
   output logic             done,
   output logic             halted,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int unsigned RST_W  = $clog2(RST_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(HALT_HOLD + 1);

   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HALT_HOLD - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [RST_W-1:0]  rst_cnt, rst_cnt_d;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
   logic [CNT_W-1:0]  cycle_d;
   logic              halted_d, timeout_d;
   logic              cpu_rst_d, cpu_en_d, running_d, done_d;
   logic              halt_hit, time_hit;

   // Next-state and next-output logic; the CPU advances only on cycles where
   // the registered cpu_en is high, so counting and halt sampling follow it.
   always_comb begin
      state_d    = state;
      rst_cnt_d  = rst_cnt;
      hold_cnt_d = hold_cnt;
      cycle_d    = cycle_count;
      halted_d   = halted;
      timeout_d  = timeout;
      halt_hit   = 1'b0;
      time_hit   = 1'b0;

      unique case (state)
         ST_RESET: begin
            if (restart) begin
               rst_cnt_d = '0;
            end else if (rst_cnt == RST_LAST) begin
               state_d = ST_RUN;
            end else begin
               rst_cnt_d = rst_cnt + RST_W'(1);
            end
         end
         ST_RUN: begin
            if (restart) begin
               state_d    = ST_RESET;
               rst_cnt_d  = '0;
               hold_cnt_d = '0;
               cycle_d    = '0;
               halted_d   = 1'b0;
               timeout_d  = 1'b0;
            end else if (cpu_en) begin
               cycle_d = cycle_count + CNT_W'(1);
               if (halt_in) begin
                  hold_cnt_d = hold_cnt + HOLD_W'(1);
                  halt_hit   = (hold_cnt == HOLD_LAST);
               end else begin
                  hold_cnt_d = '0;
               end
               time_hit = (cycle_count == CNT_LAST);
               // Halt takes precedence when both end the run on one edge
               if (halt_hit) begin
                  state_d  = ST_DONE;
                  halted_d = 1'b1;
               end else if (time_hit) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (restart) begin
               state_d    = ST_RESET;
               rst_cnt_d  = '0;
               hold_cnt_d = '0;
               cycle_d    = '0;
               halted_d   = 1'b0;
               timeout_d  = 1'b0;
            end
         end
         default: begin
            state_d    = ST_RESET;
            rst_cnt_d  = '0;
            hold_cnt_d = '0;
            cycle_d    = '0;
            halted_d   = 1'b0;
            timeout_d  = 1'b0;
         end
      endcase

      cpu_rst_d = (state_d == ST_RESET);
      cpu_en_d  = (state_d == ST_RUN) && !pause;
      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RESET;
         rst_cnt     <= '0;
         hold_cnt    <= '0;
         cycle_count <= '0;
         cpu_rst     <= 1'b1;
         cpu_en      <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_d;
         rst_cnt     <= rst_cnt_d;
         hold_cnt    <= hold_cnt_d;
         cycle_count <= cycle_d;
         cpu_rst     <= cpu_rst_d;
         cpu_en      <= cpu_en_d;
         running     <= running_d;
         done        <= done_d;
         halted      <= halted_d;
         timeout     <= timeout_d;
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: default-budget timeout, pause, restart and
// reset on one instance; halt, glitching halt and halt/timeout tie on small ones.
module tb_cpu_run_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        halt_a = 1'b0, pause_a = 1'b0, restart_a = 1'b0;
   logic        cpu_rst_a, cpu_en_a, running_a, done_a, halted_a, timeout_a;
   logic [31:0] count_a;

   logic        halt_b = 1'b0, pause_b = 1'b0, restart_b = 1'b0;
   logic        cpu_rst_b, cpu_en_b, running_b, done_b, halted_b, timeout_b;
   logic [31:0] count_b;

   logic        halt_c = 1'b0, pause_c = 1'b0, restart_c = 1'b0;
   logic        cpu_rst_c, cpu_en_c, running_c, done_c, halted_c, timeout_c;
   logic [31:0] count_c;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_run_ctrl dut_a (
      .clk(clk), .rst(rst), .halt_in(halt_a), .pause(pause_a), .restart(restart_a),
      .cpu_rst(cpu_rst_a), .cpu_en(cpu_en_a), .running(running_a), .done(done_a),
      .halted(halted_a), .timeout(timeout_a), .cycle_count(count_a)
   );

   cpu_run_ctrl #(.MAX_CYCLES(20), .HALT_HOLD(4)) dut_b (
      .clk(clk), .rst(rst), .halt_in(halt_b), .pause(pause_b), .restart(restart_b),
      .cpu_rst(cpu_rst_b), .cpu_en(cpu_en_b), .running(running_b), .done(done_b),
      .halted(halted_b), .timeout(timeout_b), .cycle_count(count_b)
   );

   cpu_run_ctrl #(.MAX_CYCLES(10), .HALT_HOLD(4)) dut_c (
      .clk(clk), .rst(rst), .halt_in(halt_c), .pause(pause_c), .restart(restart_c),
      .cpu_rst(cpu_rst_c), .cpu_en(cpu_en_c), .running(running_c), .done(done_c),
      .halted(halted_c), .timeout(timeout_c), .cycle_count(count_c)
   );

   // One-edge reset pulse, leaving the bench on a negedge
   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({cpu_rst_a, cpu_en_a, running_a, done_a, halted_a, timeout_a} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 100000",
                  {cpu_rst_a, cpu_en_a, running_a, done_a, halted_a, timeout_a});
      end
      n_checks++;
      if (count_a !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d want 0", count_a);
      end
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (!cpu_rst_a) break;
         n++;
         @(negedge clk);
      end
      n_checks++;
      if (n !== 5) begin
         n_fail++;
         $display("FAIL reset_len: got %0d cycles want 5", n);
      end
      n_checks++;
      if ({cpu_en_a, running_a} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_release_en: got %b want 11", {cpu_en_a, running_a});
      end
   endtask

   task automatic test_timeout();
      int  en_n;
      logic bad;
      en_n = 0;
      for (int i = 0; i < 10100; i++) begin
         if (done_a) break;
         if (cpu_en_a) en_n++;
         @(negedge clk);
      end
      n_checks++;
      if ({done_a, timeout_a, halted_a, cpu_en_a, running_a} !== 5'b11000) begin
         n_fail++;
         $display("FAIL timeout_flags: got %b want 11000",
                  {done_a, timeout_a, halted_a, cpu_en_a, running_a});
      end
      n_checks++;
      if (count_a !== 32'd10000) begin
         n_fail++;
         $display("FAIL timeout_count: got %0d want 10000", count_a);
      end
      n_checks++;
      if (en_n !== 10000) begin
         n_fail++;
         $display("FAIL timeout_enabled_cycles: got %0d want 10000", en_n);
      end
      bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (count_a !== 32'd10000 || done_a !== 1'b1 || cpu_en_a !== 1'b0 || cpu_rst_a !== 1'b0)
            bad = 1'b1;
      end
      n_checks++;
      if (bad !== 1'b0) begin
         n_fail++;
         $display("FAIL done_hold: got count %0d done %b want 10000 1", count_a, done_a);
      end
   endtask

   task automatic test_pause();
      int   en_n, i_done;
      logic [31:0] frozen;
      logic bad;
      pulse_rst();
      for (int i = 0; i < 20; i++) begin
         if (cpu_en_a) break;
         @(negedge clk);
      end
      en_n = 0; i_done = -1; bad = 1'b0; frozen = '0;
      for (int i = 0; i < 10200; i++) begin
         if (done_a) begin
            i_done = i;
            break;
         end
         if (i == 100) pause_a = 1'b1;
         if (i == 150) pause_a = 1'b0;
         if (i == 101) frozen = count_a;
         if (i >= 101 && i <= 150 && (cpu_en_a !== 1'b0 || count_a !== frozen)) bad = 1'b1;
         if (cpu_en_a) en_n++;
         @(negedge clk);
      end
      n_checks++;
      if (bad !== 1'b0 || frozen !== 32'd101) begin
         n_fail++;
         $display("FAIL pause_freeze: got frozen %0d want 101, err %b", frozen, bad);
      end
      n_checks++;
      if (i_done !== 10050) begin
         n_fail++;
         $display("FAIL pause_done_cycle: got %0d want 10050", i_done);
      end
      n_checks++;
      if (count_a !== 32'd10000 || en_n !== 10000 || timeout_a !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_budget: got count %0d en %0d to %b want 10000 10000 1",
                  count_a, en_n, timeout_a);
      end
   endtask

   task automatic test_restart();
      int n;
      // restart from DONE
      @(negedge clk);
      restart_a = 1'b1;
      @(negedge clk);
      restart_a = 1'b0;
      n_checks++;
      if ({cpu_rst_a, cpu_en_a, done_a, timeout_a, halted_a} !== 5'b10000 || count_a !== 32'd0) begin
         n_fail++;
         $display("FAIL restart_done_clear: got %b cnt %0d want 10000 cnt 0",
                  {cpu_rst_a, cpu_en_a, done_a, timeout_a, halted_a}, count_a);
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (!cpu_rst_a) break;
         n++;
         @(negedge clk);
      end
      n_checks++;
      if (n !== 5) begin
         n_fail++;
         $display("FAIL restart_done_len: got %0d want 5", n);
      end
      repeat (30) @(negedge clk);
      n_checks++;
      if (count_a !== 32'd30) begin
         n_fail++;
         $display("FAIL restart_run_count: got %0d want 30", count_a);
      end
      // restart mid-run
      restart_a = 1'b1;
      @(negedge clk);
      restart_a = 1'b0;
      n_checks++;
      if ({cpu_rst_a, cpu_en_a, running_a} !== 3'b100 || count_a !== 32'd0) begin
         n_fail++;
         $display("FAIL restart_run_clear: got %b cnt %0d want 100 cnt 0",
                  {cpu_rst_a, cpu_en_a, running_a}, count_a);
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (!cpu_rst_a) break;
         n++;
         @(negedge clk);
      end
      n_checks++;
      if (n !== 5) begin
         n_fail++;
         $display("FAIL restart_run_len: got %0d want 5", n);
      end
      // one-edge rst mid-run
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({cpu_rst_a, cpu_en_a, running_a, done_a, halted_a, timeout_a} !== 6'b100000 ||
          count_a !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_mid_run: got %b cnt %0d want 100000 cnt 0",
                  {cpu_rst_a, cpu_en_a, running_a, done_a, halted_a, timeout_a}, count_a);
      end
   endtask

   task automatic test_halt();
      pulse_rst();
      for (int i = 0; i < 60; i++) begin
         if (done_b) break;
         if (count_b == 32'd7) halt_b = 1'b1;
         @(negedge clk);
      end
      halt_b = 1'b0;
      n_checks++;
      if ({done_b, halted_b, timeout_b, cpu_en_b} !== 4'b1100) begin
         n_fail++;
         $display("FAIL halt_flags: got %b want 1100", {done_b, halted_b, timeout_b, cpu_en_b});
      end
      n_checks++;
      if (count_b !== 32'd11) begin
         n_fail++;
         $display("FAIL halt_count: got %0d want 11", count_b);
      end
   endtask

   task automatic test_glitch_halt();
      logic [7:0] pat;
      logic       early;
      pat   = 8'b1111_0111;
      early = 1'b0;
      pulse_rst();
      for (int i = 0; i < 20; i++) begin
         if (count_b == 32'd2) break;
         @(negedge clk);
      end
      for (int k = 0; k < 8; k++) begin
         halt_b = pat[k];
         @(negedge clk);
         if (k < 7 && done_b !== 1'b0) early = 1'b1;
      end
      halt_b = 1'b0;
      n_checks++;
      if (early !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_early_done: got early %b want 0", early);
      end
      n_checks++;
      if ({done_b, halted_b, timeout_b} !== 3'b110 || count_b !== 32'd10) begin
         n_fail++;
         $display("FAIL glitch_halt: got %b cnt %0d want 110 cnt 10",
                  {done_b, halted_b, timeout_b}, count_b);
      end
   endtask

   task automatic test_halt_timeout_tie();
      pulse_rst();
      for (int i = 0; i < 40; i++) begin
         if (done_c) break;
         if (count_c == 32'd6) halt_c = 1'b1;
         @(negedge clk);
      end
      halt_c = 1'b0;
      n_checks++;
      if ({done_c, halted_c, timeout_c} !== 3'b110) begin
         n_fail++;
         $display("FAIL tie_flags: got %b want 110", {done_c, halted_c, timeout_c});
      end
      n_checks++;
      if (count_c !== 32'd10) begin
         n_fail++;
         $display("FAIL tie_count: got %0d want 10", count_c);
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_pause();
      test_restart();
      test_halt();
      test_glitch_halt();
      test_halt_timeout_tie();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
